buffer: RTL and testbench

- Fixed-latency delay line (shift-register buffer) for the NTT datapath.
- Every clock, one WIDTH-bit word is taken from data_in.
- Each word appears on data_out exactly DEPTH cycles later.
- valid_out marks when the pipeline holds only post-reset data, i.e. after the first DEPTH words have been loaded.
- Used to align operands or twiddles against pipelined butterfly latency.

---
 rtl/buffer_pkg.sv | 17 +
 rtl/buffer_if.sv | 27 ++
 rtl/buffer_stage.sv | 29 ++
 rtl/buffer.sv | 76 +++++++
 tb/tb_buffer.sv | 130 +++++++++++++
 5 files changed

// File: rtl/buffer_pkg.sv
// buffer_pkg: shared definitions for the fixed-latency delay line.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default word width and latency
//   cnt_width(depth)              : width of a counter that must reach depth
//   word_t                        : data word at the default width
package buffer_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 2;

  // The fill counter has to hold the value DEPTH itself, hence depth+1.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  typedef logic [DEFAULT_WIDTH-1:0] word_t;

endpackage : buffer_pkg

// File: rtl/buffer_if.sv
// buffer_if: data bundle of the delay line.
//   data_in   : word entering the line (sampled every clock)
//   data_out  : oldest stored word
//   valid_out : data_out carries a word sampled after the last reset
// modport master : producer/consumer side (drives data_in)
// modport slave  : delay-line side (drives data_out, valid_out)
interface buffer_if #(
  parameter int WIDTH = buffer_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             valid_out;

  modport master (
    output data_in,
    input  data_out,
    input  valid_out
  );

  modport slave (
    input  data_in,
    output data_out,
    output valid_out
  );

endinterface : buffer_if

// File: rtl/buffer_stage.sv
// buffer_stage: one WIDTH-bit register of the delay-line chain.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, clears the register to 0
//   d_i  : word from the previous stage (or the line input)
//   q_o  : registered word
module buffer_stage
  import buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= d_i;
    end
  end

  assign q_o = data_q;

endmodule : buffer_stage

// File: rtl/buffer.sv
// buffer: fixed-latency delay line used to align NTT operands/twiddles
// with the pipelined butterfly latency. Every clock one word enters;
// it reappears on data_out exactly DEPTH clocks later.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset (clears stages, counter, valid)
//   bus  : buffer_if.slave -- data_in in, data_out / valid_out out
module buffer
  import buffer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic        clk,
  input  logic        rst,
  buffer_if.slave     bus
);

  localparam int CW = cnt_width(DEPTH);

  if (DEPTH < 1) begin : g_depth_check
    $error("buffer: DEPTH must be at least 1");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Stage 0 takes the line input; every later stage takes its predecessor.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    logic [WIDTH-1:0] stage_d;

    if (gi == 0) begin : g_head
      assign stage_d = bus.data_in;
    end else begin : g_link
      assign stage_d = stage_q[gi-1];
    end

    buffer_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk (clk),
      .rst (rst),
      .d_i (stage_d),
      .q_o (stage_q[gi])
    );
  end

  // Fill tracking: the counter saturates at DEPTH. valid is set on the edge
  // that moves the counter from DEPTH-1 to DEPTH, which is exactly the edge
  // where the first post-reset word lands in the last stage.
  logic [CW-1:0] fill_cnt_q, fill_cnt_d;
  logic          valid_q, valid_d;

  always_comb begin
    fill_cnt_d = fill_cnt_q;
    valid_d    = valid_q;
    if (fill_cnt_q != CW'(DEPTH)) begin
      fill_cnt_d = fill_cnt_q + CW'(1);
    end
    if (fill_cnt_q == CW'(DEPTH - 1)) begin
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill_cnt_q <= '0;
      valid_q    <= 1'b0;
    end else begin
      fill_cnt_q <= fill_cnt_d;
      valid_q    <= valid_d;
    end
  end

  assign bus.data_out  = stage_q[DEPTH-1];
  assign bus.valid_out = valid_q;

endmodule : buffer

// File: tb/tb_buffer.sv
// tb_buffer: directed self-checking bench for the delay line at
// DEPTH=2/WIDTH=32, DEPTH=1/WIDTH=32 and DEPTH=5/WIDTH=64.
module tb_buffer;
  import buffer_pkg::*;

  logic clk;
  logic rst;

  buffer_if #(.WIDTH(32)) bus2 ();
  buffer_if #(.WIDTH(32)) bus1 ();
  buffer_if #(.WIDTH(64)) bus5 ();

  buffer #(.WIDTH(32), .DEPTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2.slave));
  buffer #(.WIDTH(32), .DEPTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1.slave));
  buffer #(.WIDTH(64), .DEPTH(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));

  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  initial begin
    word_t     pat [8];
    logic [63:0] sb [$];
    logic [63:0] v;

    clk = 1'b0;
    rst = 1'b1;
    bus2.data_in = 32'hDEADBEEF;
    bus1.data_in = 32'hDEADBEEF;
    bus5.data_in = 64'hDEADBEEF_DEADBEEF;

    // Reset with garbage on the inputs
    step();
    chk("rst_d2_data", 64'(bus2.data_out), 64'h0);
    chk("rst_d2_valid", 64'(bus2.valid_out), 64'h0);
    chk("rst_d1_valid", 64'(bus1.valid_out), 64'h0);
    chk("rst_d5_data", bus5.data_out, 64'h0);
    chk("rst_d5_valid", 64'(bus5.valid_out), 64'h0);
    rst = 1'b0;
    bus1.data_in = 32'h0;
    bus5.data_in = 64'h0;

    // DEPTH=2 fill: 1,2,3,4
    bus2.data_in = 32'd1; step();
    $display("d2 in=1 out=0x%0h valid=%0b", bus2.data_out, bus2.valid_out);
    chk("fill_e1_valid", 64'(bus2.valid_out), 64'h0);
    chk("fill_e1_data", 64'(bus2.data_out), 64'h0);
    bus2.data_in = 32'd2; step();
    $display("d2 in=2 out=0x%0h valid=%0b", bus2.data_out, bus2.valid_out);
    chk("fill_e2_data", 64'(bus2.data_out), 64'd1);
    chk("fill_e2_valid", 64'(bus2.valid_out), 64'h1);
    bus2.data_in = 32'd3; step();
    chk("fill_e3_data", 64'(bus2.data_out), 64'd2);
    bus2.data_in = 32'd4; step();
    chk("fill_e4_data", 64'(bus2.data_out), 64'd3);
    chk("fill_e4_valid", 64'(bus2.valid_out), 64'h1);

    // Stream of 10 words 0x10..0x19 (first output is the trailing 4)
    for (int i = 0; i < 10; i++) begin
      bus2.data_in = 32'h10 + 32'(i);
      step();
      $display("d2 in=0x%0h out=0x%0h valid=%0b", bus2.data_in, bus2.data_out, bus2.valid_out);
      chk("stream_data", 64'(bus2.data_out), (i == 0) ? 64'd4 : 64'h10 + 64'(i - 1));
    end

    // Mid-stream reset
    rst = 1'b1; bus2.data_in = 32'h99; step();
    chk("mid_rst_data", 64'(bus2.data_out), 64'h0);
    chk("mid_rst_valid", 64'(bus2.valid_out), 64'h0);
    rst = 1'b0;
    bus2.data_in = 32'hA; step();
    chk("refill_e1_valid", 64'(bus2.valid_out), 64'h0);
    chk("refill_e1_data", 64'(bus2.data_out), 64'h0);
    bus2.data_in = 32'hB; step();
    chk("refill_e2_data", 64'(bus2.data_out), 64'hA);
    chk("refill_e2_valid", 64'(bus2.valid_out), 64'h1);
    bus2.data_in = 32'h0; step();
    chk("refill_e3_data", 64'(bus2.data_out), 64'hB);

    // Pattern integrity through the DEPTH=2 line
    for (int i = 0; i < 8; i++) pat[i] = (i % 2 == 0) ? 32'hFFFFFFFF : 32'h00000000;
    for (int i = 0; i < 8; i++) begin
      bus2.data_in = pat[i];
      step();
      $display("d2 pat in=0x%0h out=0x%0h", bus2.data_in, bus2.data_out);
      if (i >= 1) chk("pattern", 64'(bus2.data_out), 64'(pat[i-1]));
    end

    // DEPTH=1
    rst = 1'b1; step(); rst = 1'b0;
    chk("d1_rst_data", 64'(bus1.data_out), 64'h0);
    bus1.data_in = 32'd7; step();
    $display("d1 in=7 out=0x%0h valid=%0b", bus1.data_out, bus1.valid_out);
    chk("d1_data", 64'(bus1.data_out), 64'd7);
    chk("d1_valid", 64'(bus1.valid_out), 64'h1);
    bus1.data_in = 32'hFFFFFFFF; step();
    chk("d1_data2", 64'(bus1.data_out), 64'hFFFFFFFF);

    // DEPTH=5, WIDTH=64 with scoreboard; upper bits exercised too
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      v = 64'(i) | (64'(i) << 40);
      bus5.data_in = v;
      sb.push_back(v);
      step();
      chk("d5_valid", 64'(bus5.valid_out), (i >= 4) ? 64'h1 : 64'h0);
      if (sb.size() == 5) begin
        v = sb.pop_front();
        $display("d5 edge=%0d out=0x%0h exp=0x%0h", i + 1, bus5.data_out, v);
        chk("d5_data", bus5.data_out, v);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_buffer
